// File: rtl/cpu_sequencer.sv
// cpu_sequencer: architectural state around control_unit for the 8-bit
// multi-cycle CPU. It holds the FSM state, PC, IR, zero flag, halt latch and
// retired-instruction counter, and gates advance for run/single-step debug.
//
// state      | meaning
// -----------+-----------------------------------------------
// FETCH      | 000 instruction boundary; only place run/step can pause
// DECODE     | 001 decode instruction register
// EXECUTE    | 010 ALU operation / branch resolution
// MEMORY     | 011 data memory access
// WRITEBACK  | 100 register write-back
// HALT_STATE | 101 halted; frozen until reset
// (110/111 are illegal and fold back to FETCH)
module cpu_sequencer #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16,
  parameter int RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic [2:0]           next_state,
  input  logic                 pc_we,
  input  logic                 pc_sel,
  input  logic [3:0]           pc_offset,
  input  logic                 ir_we,
  input  logic                 zf_we,
  input  logic                 halt,
  input  logic [7:0]           mem_rdata,
  input  logic                 alu_zero,
  output logic [2:0]           state,
  output logic [7:0]           instr,
  output logic                 zf,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 halted,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'b000,
    ST_DECODE    = 3'b001,
    ST_EXECUTE   = 3'b010,
    ST_MEMORY    = 3'b011,
    ST_WRITEBACK = 3'b100,
    ST_HALT      = 3'b101
  } state_t;

  state_t                state_q;
  state_t                state_load;
  logic                  adv;
  logic                  halting;
  logic                  retire;
  logic                  cnt_max;
  logic [PC_WIDTH-1:0]   offset_ext;
  logic [PC_WIDTH-1:0]   pc_next;

  assign state = state_q;

  // Advance unless halted; a pause can only hold the block at FETCH.
  assign adv = !halted && (run || (state_q != ST_FETCH) || step);

  // Halt request from either the dedicated strobe or the FSM encoding.
  assign halting = halt || (next_state == ST_HALT);

  // Decode next_state, folding the two unused encodings back to FETCH.
  always_comb begin
    state_load = ST_FETCH;
    case (next_state)
      3'b000:  state_load = ST_FETCH;
      3'b001:  state_load = ST_DECODE;
      3'b010:  state_load = ST_EXECUTE;
      3'b011:  state_load = ST_MEMORY;
      3'b100:  state_load = ST_WRITEBACK;
      3'b101:  state_load = ST_HALT;
      default: state_load = ST_FETCH;
    endcase
  end

  // Next PC: increment or relative branch, wrapping modulo 2^PC_WIDTH.
  assign offset_ext = {{(PC_WIDTH-4){pc_offset[3]}}, pc_offset};
  assign pc_next    = pc_sel ? (pc + offset_ext) : (pc + {{(PC_WIDTH-1){1'b0}}, 1'b1});

  // An instruction retires when it returns to FETCH or halts from a non-FETCH state.
  assign retire  = (state_q != ST_FETCH) && (halting || (state_load == ST_FETCH));
  assign cnt_max = &instr_count;

  assign busy = (state_q != ST_FETCH) && !halted;

  // Architectural state update; reset first, then everything gated by adv.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc          <= PC_WIDTH'(RESET_PC);
      instr       <= 8'h00;
      zf          <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else if (adv) begin
      if (halting) begin
        state_q <= ST_HALT;
        halted  <= 1'b1;
      end else begin
        state_q <= state_load;
      end
      if (pc_we) pc <= pc_next;
      if (ir_we) instr <= mem_rdata;
      if (zf_we) zf <= alu_zero;
      if (retire && !cnt_max) instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer. A second instance with a 2-bit counter
// shares all stimulus and shows counter saturation.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, step;
  logic [2:0]  next_state;
  logic        pc_we, pc_sel, ir_we, zf_we, halt, alu_zero;
  logic [3:0]  pc_offset;
  logic [7:0]  mem_rdata;

  logic [2:0]  state, state_s;
  logic [7:0]  instr, instr_s;
  logic        zf, zf_s, halted, halted_s, busy, busy_s;
  logic [7:0]  pc, pc_s;
  logic [15:0] instr_count;
  logic [1:0]  instr_count_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_WIDTH(8), .CNT_WIDTH(16), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .next_state(next_state),
    .pc_we(pc_we), .pc_sel(pc_sel), .pc_offset(pc_offset), .ir_we(ir_we),
    .zf_we(zf_we), .halt(halt), .mem_rdata(mem_rdata), .alu_zero(alu_zero),
    .state(state), .instr(instr), .zf(zf), .pc(pc), .halted(halted),
    .busy(busy), .instr_count(instr_count)
  );

  cpu_sequencer #(.PC_WIDTH(8), .CNT_WIDTH(2), .RESET_PC(0)) dut_sat (
    .clk(clk), .reset(reset), .run(run), .step(step), .next_state(next_state),
    .pc_we(pc_we), .pc_sel(pc_sel), .pc_offset(pc_offset), .ir_we(ir_we),
    .zf_we(zf_we), .halt(halt), .mem_rdata(mem_rdata), .alu_zero(alu_zero),
    .state(state_s), .instr(instr_s), .zf(zf_s), .pc(pc_s), .halted(halted_s),
    .busy(busy_s), .instr_count(instr_count_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of control_unit outputs, then sample 1ns after the edge.
  task automatic cyc(input logic [2:0] ns, input logic pw, input logic ps,
                     input logic [3:0] off, input logic iw, input logic [7:0] rd,
                     input logic zw, input logic az, input logic h);
    next_state = ns; pc_we = pw; pc_sel = ps; pc_offset = off;
    ir_we = iw; mem_rdata = rd; zf_we = zw; alu_zero = az; halt = h;
    @(posedge clk);
    #1;
  endtask

  // FETCH -> DECODE -> EXECUTE -> FETCH with IR load and PC update.
  task automatic instr3(input logic [7:0] rd, input logic ps, input logic [3:0] off);
    cyc(3'd1, 0, 0, 4'h0, 1, rd,    0, 0, 0);
    cyc(3'd2, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    cyc(3'd0, 1, ps, off, 0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; step = $urandom_range(0, 1);
    next_state = 3'($urandom); pc_we = 1'b1; pc_sel = $urandom_range(0, 1);
    pc_offset = 4'($urandom); ir_we = 1'b1; mem_rdata = 8'($urandom);
    zf_we = 1'b1; alu_zero = 1'b1; halt = $urandom_range(0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",  state, 3'b000);
    check("rst_pc",     pc, 8'h00);
    check("rst_instr",  instr, 8'h00);
    check("rst_zf",     zf, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_cnt",    instr_count, 16'd0);
    check("rst_busy",   busy, 1'b0);
    reset = 1'b0; step = 1'b0;

    // free-run fetch
    cyc(3'd1, 0, 0, 4'h0, 1, 8'hA5, 0, 0, 0);
    check("fr_instr", instr, 8'hA5);
    check("fr_state1", state, 3'd1);
    check("fr_busy1", busy, 1'b1);
    cyc(3'd2, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    check("fr_busy2", busy, 1'b1);
    check("fr_pc_hold", pc, 8'h00);
    cyc(3'd0, 1, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    check("fr_pc", pc, 8'h01);
    check("fr_cnt", instr_count, 16'd1);
    check("fr_busy3", busy, 1'b0);

    // branch wrap both directions
    instr3(8'h11, 0, 4'h0);
    check("br_pc2", pc, 8'h02);
    instr3(8'h22, 1, 4'hC);
    check("br_back", pc, 8'hFE);
    instr3(8'h33, 1, 4'h7);
    check("br_fwd", pc, 8'h05);
    check("br_cnt", instr_count, 16'd4);
    check("sat_cnt4", instr_count_s, 2'd3);

    // pause at FETCH
    run = 1'b0;
    repeat (5) cyc(3'd1, 1, 1, 4'h3, 1, 8'hFF, 1, 1, 0);
    check("pause_state", state, 3'd0);
    check("pause_pc", pc, 8'h05);
    check("pause_cnt", instr_count, 16'd4);
    check("pause_instr", instr, 8'h33);
    check("pause_zf", zf, 1'b0);

    // single step
    step = 1'b1;
    cyc(3'd1, 0, 0, 4'h0, 1, 8'h44, 0, 0, 0);
    step = 1'b0;
    check("step_state", state, 3'd1);
    check("step_instr", instr, 8'h44);
    cyc(3'd2, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    cyc(3'd0, 1, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    check("step_pc", pc, 8'h06);
    check("step_cnt", instr_count, 16'd5);
    cyc(3'd1, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    check("step_hold", state, 3'd0);

    // drop run mid-instruction
    run = 1'b1;
    cyc(3'd1, 0, 0, 4'h0, 1, 8'h55, 0, 0, 0);
    run = 1'b0;
    cyc(3'd2, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    check("drop_state2", state, 3'd2);
    cyc(3'd0, 1, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    check("drop_pc", pc, 8'h07);
    check("drop_cnt", instr_count, 16'd6);
    check("sat_cnt6", instr_count_s, 2'd3);
    cyc(3'd1, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    check("drop_hold", state, 3'd0);
    check("drop_hold_cnt", instr_count, 16'd6);

    // illegal next_state folds to FETCH
    run = 1'b1;
    cyc(3'd1, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    cyc(3'd7, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    check("ill7_state", state, 3'd0);
    check("ill7_cnt", instr_count, 16'd7);
    cyc(3'd1, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    cyc(3'd6, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    check("ill6_state", state, 3'd0);
    check("ill6_cnt", instr_count, 16'd8);
    cyc(3'd7, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    check("ill_fetch_cnt", instr_count, 16'd8);

    // halt in EXECUTE with same-cycle writes
    cyc(3'd1, 0, 0, 4'h0, 1, 8'h66, 0, 0, 0);
    cyc(3'd2, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    cyc(3'd3, 1, 0, 4'h0, 0, 8'h00, 1, 1, 1);
    check("halt_zf", zf, 1'b1);
    check("halt_flag", halted, 1'b1);
    check("halt_state", state, 3'd5);
    check("halt_cnt", instr_count, 16'd9);
    check("halt_pc", pc, 8'h08);
    check("halt_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run = i[0]; step = 1'b1;
      cyc(3'd1, 1, 1, 4'h7, 1, 8'hAA, 1, 0, 0);
    end
    step = 1'b0; run = 1'b1;
    check("frz_state", state, 3'd5);
    check("frz_pc", pc, 8'h08);
    check("frz_instr", instr, 8'h66);
    check("frz_zf", zf, 1'b1);
    check("frz_cnt", instr_count, 16'd9);
    check("frz_sat", instr_count_s, 2'd3);

    // reset exits halt
    reset = 1'b1;
    cyc(3'd0, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    reset = 1'b0;
    check("rh_state", state, 3'd0);
    check("rh_halted", halted, 1'b0);
    check("rh_cnt", instr_count, 16'd0);

    // halt via next_state encoding
    cyc(3'd1, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    cyc(3'd5, 0, 0, 4'h0, 0, 8'h00, 0, 0, 0);
    check("nsh_halted", halted, 1'b1);
    check("nsh_state", state, 3'd5);
    check("nsh_cnt", instr_count, 16'd1);
    check("nsh_sat", instr_count_s, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Architectural state holder for the 8-bit multi-cycle CPU. It sits directly around control_unit: it feeds control_unit its `state`, `instr` and `zf` inputs, and consumes control_unit's `next_state`, `pc_we`/`pc_sel`/`pc_offset`, `ir_we`, `zf_we` and `halt` outputs.
- It owns the FSM state register, program counter, instruction register, zero flag, halt latch and a retired-instruction counter.
- It provides run/single-step gating for debug.

Parameters:
PC_WIDTH, 8, width of program counter.
CNT_WIDTH, 16, width of retired-instruction counter.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  1 = free-run; 0 = pause at FETCH, advance only on step
step  input  1  while paused in FETCH, a 1 on this input advances one full instruction
next_state  input  3  next FSM state from control_unit
pc_we  input  1  PC write enable from control_unit
pc_sel  input  1  0 = PC+1, 1 = PC + sign-extended pc_offset
pc_offset  input  4  signed relative branch offset (two's complement, -8..+7)
ir_we  input  1  load instruction register from mem_rdata
zf_we  input  1  load zero flag from alu_zero
halt  input  1  halt request from control_unit
mem_rdata  input  8  memory read data
alu_zero  input  1  ALU result-is-zero
state  output  3  current FSM state, to control_unit
instr  output  8  instruction register, to control_unit
zf  output  1  zero flag, to control_unit
pc  output  PC_WIDTH  program counter, to memory address mux
halted  output  1  halt latch
busy  output  1  state != FETCH and not halted (combinational from registers)
instr_count  output  CNT_WIDTH  retired instructions, saturating

Behaviour:
- State encoding: FETCH=000, DECODE=001, EXECUTE=010, MEMORY=011, WRITEBACK=100, HALT_STATE=101.
- Reset (synchronous, highest priority):
  - state=FETCH, pc=RESET_PC, instr=0, zf=0, halted=0, instr_count=0.
  - busy=0 follows.
- Advance enable (combinational): adv = !halted && (run || state!=FETCH || step).
  - Pausing only ever occurs at an instruction boundary (FETCH).
  - Dropping run mid-instruction lets the current instruction complete, then the block holds in FETCH.
  - step is level-sampled and only acts in FETCH. Holding step=1 while run=0 executes back-to-back instructions. step outside FETCH has no effect.
- When adv=1, on the clock edge:
  - state <= next_state. Values 110/111 load FETCH.
  - pc_we=1: pc <= pc + 1 if pc_sel=0, else pc <= pc + sign_extend(pc_offset). Modulo 2^PC_WIDTH, wrap-around in both directions.
  - ir_we=1: instr <= mem_rdata.
  - zf_we=1: zf <= alu_zero.
  - Retire: if state!=FETCH and the loaded state is FETCH, instr_count += 1. Saturates at all-ones; no wrap.
  - If halt=1 or next_state==HALT_STATE:
    - halted <= 1 and state <= HALT_STATE.
    - pc/ir/zf writes requested in that same cycle still take effect.
    - instr_count increments if state!=FETCH (the halting instruction counts as retired).
- When adv=0: all registers hold. pc_we/ir_we/zf_we are ignored.
- Halted:
  - state stays HALT_STATE and all registers are frozen.
  - run, step and control inputs are ignored.
  - Only reset exits.
- Latency: every register update is visible one cycle after the enabling edge. No combinational path from inputs to state/instr/zf/pc.

Test Plan:
- Reset: assert reset 2 cycles with run=1 and random inputs -> state=000, pc=0, instr=00, zf=0, halted=0, instr_count=0, busy=0.
- Free-run fetch: run=1, next_state sequence 001,010,000, ir_we=1 with mem_rdata=A5 in FETCH, pc_we=1/pc_sel=0 in EXECUTE -> instr=A5 after edge 1, pc=01 after edge 3, instr_count=1, busy high for 2 cycles.
- Branch wrap: pc=02, pc_sel=1, pc_offset=1100 (-4), pc_we=1 -> pc=FE. Then pc=FE, pc_offset=0111 -> pc=05.
- Pause/step: run=0 in FETCH, step=0 for 5 cycles -> state/pc/count unchanged. Pulse step one cycle -> one full instruction executes, then state=FETCH and holds. Drop run in DECODE -> instruction completes and holds in FETCH.
- Halt: halt=1 in EXECUTE with zf_we=1, alu_zero=1 -> zf=1, halted=1, state=101, instr_count incremented. Further pc_we/step/run toggling -> no change. Reset -> state=FETCH, halted=0.
- Counter saturation / illegal state: instr_count forced near FFFF via CNT_WIDTH=2 build, 5 instructions -> count=3. next_state=111 with adv -> state=000.
